// File: rtl/gcm_tag_check.sv
// Receive-side GHASH tag checker: folded GF(2^128) multiply, tag = GHASH ^ E(K,J0), compare with received tag.
// Optional macro GCM_TAG_TRUNC_EN restricts the compare to the top TAG_BITS bits.
module gcm_tag_check #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_BITS       = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] h,
  input  logic [127:0] ek_j0,
  input  logic [63:0]  aad_len,
  input  logic [63:0]  ct_len,
  input  logic [127:0] tag_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         busy,
  output logic         done,
  output logic [127:0] tag_out,
  output logic         tag_ok,
  output logic         len_err
);

  localparam int unsigned N = 128 / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CYC_LAST = CW'(N - 1);
  localparam logic [127:0] R_POLY = {8'hE1, 120'h0};
`ifdef GCM_TAG_TRUNC_EN
  localparam logic [127:0] CMP_MASK = ~((128'd1 << (128 - TAG_BITS)) - 128'd1);
`else
  localparam logic [127:0] CMP_MASK = '1;
`endif

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bpc_chk
    $error("gcm_tag_check: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  if (TAG_BITS % 8 != 0 || TAG_BITS < 96 || TAG_BITS > 128) begin : g_tag_chk
    $error("gcm_tag_check: TAG_BITS must be a multiple of 8 in 96..128");
  end

  typedef enum logic [2:0] {IDLE, LOAD, MUL, LEN, FIN, DONE} state_t;
  state_t state, state_n;

  logic [127:0] h_r, ek_r, tag_in_r;
  logic [63:0]  aad_r, ct_r;
  logic [127:0] x, v, z, y;
  logic [127:0] x_step, v_step, z_step;
  logic [CW-1:0] cyc;
  logic [57:0]  cnt, exp_cnt;
  logic         last_r, len_done;
  logic [127:0] tag_c;
  logic         lerr_c;

  // BITS_PER_CYCLE iterations of Algorithm 1; X is shifted left so its MSB is always the next bit
  always_comb begin
    z_step = z;
    v_step = v;
    x_step = x;
    for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
      if (x_step[127]) z_step = z_step ^ v_step;
      v_step = v_step[0] ? ((v_step >> 1) ^ R_POLY) : (v_step >> 1);
      x_step = x_step << 1;
    end
  end

  always_comb begin
    exp_cnt = {1'b0, aad_r[63:7]} + {1'b0, ct_r[63:7]}
            + 58'(|aad_r[6:0]) + 58'(|ct_r[6:0]);
    lerr_c  = (cnt != exp_cnt);
    tag_c   = y ^ ek_r;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = (aad_len == '0 && ct_len == '0) ? LEN : LOAD;
      LOAD:       if (in_valid) state_n = MUL;
      MUL: begin
        if (cyc == CYC_LAST) begin
          if (len_done)    state_n = FIN;
          else if (last_r) state_n = LEN;
          else             state_n = LOAD;
        end
      end
      LEN:        state_n = MUL;
      FIN:        state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      h_r      <= '0;
      ek_r     <= '0;
      tag_in_r <= '0;
      aad_r    <= '0;
      ct_r     <= '0;
      x        <= '0;
      v        <= '0;
      z        <= '0;
      y        <= '0;
      cyc      <= '0;
      cnt      <= '0;
      last_r   <= 1'b0;
      len_done <= 1'b0;
      tag_out  <= '0;
      tag_ok   <= 1'b0;
      len_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            h_r      <= h;
            ek_r     <= ek_j0;
            tag_in_r <= tag_in;
            aad_r    <= aad_len;
            ct_r     <= ct_len;
            y        <= '0;
            cnt      <= '0;
            last_r   <= 1'b0;
            len_done <= 1'b0;
            tag_out  <= '0;
            tag_ok   <= 1'b0;
            len_err  <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            x      <= y ^ in_data;
            v      <= h_r;
            z      <= '0;
            cyc    <= '0;
            cnt    <= cnt + 58'd1;
            last_r <= in_last;
          end
        end
        MUL: begin
          x   <= x_step;
          v   <= v_step;
          z   <= z_step;
          cyc <= cyc + CW'(1);
          if (cyc == CYC_LAST) y <= z_step;
        end
        LEN: begin
          x        <= y ^ {aad_r, ct_r};
          v        <= h_r;
          z        <= '0;
          cyc      <= '0;
          len_done <= 1'b1;
        end
        FIN: begin
          tag_out <= tag_c;
          len_err <= lerr_c;
          tag_ok  <= (((tag_c ^ tag_in_r) & CMP_MASK) == '0) && !lerr_c;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gcm_tag_check.md
# gcm_tag_check

Receive-side GHASH tag checker for the AES-GCM datapath: consumes the AAD and ciphertext blocks arriving at the decryption end, accumulates GHASH with a folded (multi-cycle) GF(2^128) multiplier, forms the tag as GHASH ^ E(K,J0), and compares it against the received tag. It sits beside `gcm_backward`. The hash subkey H and E(K,J0) come from the existing AES core; this block only verifies integrity and never gates plaintext.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits folded per cycle; legal values 1, 2, 4, 8. N = 128/BITS_PER_CYCLE cycles per multiply.
- `TAG_BITS`, default 128: compared tag width, multiple of 8 in 96..128. Used only under `GCM_TAG_TRUNC_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a message; honoured only in IDLE or DONE.
- `h` in 128: hash subkey E(K,0^128); sampled on `start`.
- `ek_j0` in 128: E(K,J0); sampled on `start`.
- `aad_len` in 64: AAD length in bits; sampled on `start`.
- `ct_len` in 64: ciphertext length in bits; sampled on `start`.
- `tag_in` in 128: received tag; sampled on `start`.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: block accepted when `in_valid & in_ready` at a rising edge.
- `in_data` in 128: AAD blocks, then ciphertext blocks. Partial blocks are zero-padded by the sender.
- `in_last` in 1: marks the final data block.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: one-cycle pulse when the result is valid.
- `tag_out` out 128: computed tag; held until the next `start` or `rst`.
- `tag_ok` out 1: comparison result; held with `tag_out`.
- `len_err` out 1: received block count differs from the count implied by the lengths; held with `tag_out`.

## Operation
- GCM bit order: `in_data[127]` is coefficient x^0.
- Multiply uses SP 800-38D Algorithm 1, processing BITS_PER_CYCLE bits of X per cycle, MSB first. Per bit: if `X[127-i]`, Z ^= V; then V = V[0] ? (V>>1) ^ {8'hE1,120'h0} : V>>1.
- States:
  - IDLE: on `start`, latch the inputs, set Y = 0 and block count = 0. If `aad_len` and `ct_len` are both 0, go to LEN; otherwise go to LOAD.
  - LOAD: `in_ready` = 1. On accept: X = Y ^ `in_data`, V = H, Z = 0, count += 1, remember `in_last`, go to MUL.
  - MUL: run N cycles, then Y = Z. Go to LOAD if the block was not last, to LEN if it was last and the length block is pending, or to FIN if the length block is done.
  - LEN: load X = Y ^ {`aad_len`, `ct_len`}, go to MUL.
  - FIN: `tag_out` = Y ^ `ek_j0`.
    - `len_err` = (count != ceil(aad_len/128) + ceil(ct_len/128)), computed in 58-bit arithmetic.
    - `tag_ok` = (`tag_out` == `tag_in`) & !`len_err`.
    - Go to DONE.
  - DONE: `done` = 1 for the first cycle only. Accepts `start` exactly as IDLE does.
- `start` while busy: ignored.
- `in_valid` outside LOAD: ignored, because `in_ready` = 0.

## Timing
- Reset values: `in_ready`, `busy`, `done`, `tag_ok`, `len_err` = 0; `tag_out` = 0; state = IDLE. `rst` mid-message aborts, with no `done`.
- After an accept edge, `in_ready` is low for exactly N cycles. Sustained block throughput is one per N+1 cycles.
- After the last data accept: N (MUL) + 1 (LEN) + N (MUL) + 1 (FIN) cycles, then `done` is high in the next cycle. With BITS_PER_CYCLE = 1 this is 259 cycles.
- Both lengths zero: `start` edge → LEN → N cycles of MUL → FIN → `done`. Total N+3 cycles after `start`.
- `start` and `in_valid` in the same IDLE cycle: `start` is taken; the data is not consumed.
- `tag_ok` is 0 at every cycle before `done`, never transiently 1.

## Configuration
- `GCM_TAG_TRUNC_EN` defined: compare only `tag_out[127:128-TAG_BITS]` against `tag_in[127:128-TAG_BITS]`. `tag_out` is still the full 128 bits.
- `GCM_TAG_TRUNC_EN` undefined: full 128-bit compare; `TAG_BITS` is ignored.

## Test plan
- **Empty message:** `h`=66e94bd4ef8a2c3b884cfa59ca342b2e, `ek_j0`=58e2fccefa7e3061367f1d57a4e7455a, both lengths 0, `tag_in` equal to `ek_j0` → `tag_out`=58e2fccefa7e3061367f1d57a4e7455a, `tag_ok`=1, `done` at N+3 cycles after `start`.
- **Single ciphertext block:** same H/E(K,J0), `ct_len`=128, block 0388dace60b6a392f328c2b971b2fe78 with `in_last`, `tag_in`=ab6e47d42cec13bdf53a67b21257bddf → `tag_ok`=1, `len_err`=0.
- **Identity multiplier:** `h`=128'h80000000000000000000000000000000, `ek_j0`=0, `ct_len`=128, block D → `tag_out` = D ^ 128'h80.
- **Corrupted tag:** single-block case with `tag_in` bit 0 flipped → `tag_ok`=0. Under `GCM_TAG_TRUNC_EN` with `TAG_BITS`=96 → `tag_ok`=1.
- **Length mismatch:** `ct_len`=256 with only one block, sent with `in_last` → `len_err`=1, `tag_ok`=0.
- **Abort and restart:** `rst` asserted during MUL → all outputs 0 next cycle, no `done`. Then check `start` ignored while busy, and that BITS_PER_CYCLE = 8 gives identical tags with N=16.
